// File: rtl/psram_qpi_responder.sv
// Target-side ESP-PSRAM64H SPI/QPI responder: oversamples the controller pins with clk,
// decodes reset / enter-QPI / quad-write / quad-read and serves a small byte memory.
module psram_qpi_responder #(
  parameter int unsigned MEM_AW      = 10,
  parameter int unsigned WAIT_CYCLES = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       ce,
  input  logic [3:0] sio_i,
  output logic [3:0] sio_o,
  output logic       sio_oe,
  output logic       qpi_mode,
  output logic [7:0] last_cmd
);

  localparam int unsigned DEPTH = 1 << MEM_AW;
  localparam int unsigned CNT_W = $clog2(WAIT_CYCLES + 9);

  typedef enum logic [2:0] {
    S_CMD,
    S_ADDR,
    S_WAIT,
    S_WR_DATA,
    S_RD_DATA,
    S_IGNORE
  } state_e;

  // Pin synchronizers; sclk gets a third stage for edge detection
  logic       sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic       ce_s1_q, ce_s2_q;
  logic [3:0] sio_s1_q, sio_s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s1_q <= 1'b0;
      sclk_s2_q <= 1'b0;
      sclk_s3_q <= 1'b0;
      ce_s1_q   <= 1'b1;
      ce_s2_q   <= 1'b1;
      sio_s1_q  <= 4'h0;
      sio_s2_q  <= 4'h0;
    end else begin
      sclk_s1_q <= sclk;
      sclk_s2_q <= sclk_s1_q;
      sclk_s3_q <= sclk_s2_q;
      ce_s1_q   <= ce;
      ce_s2_q   <= ce_s1_q;
      sio_s1_q  <= sio_i;
      sio_s2_q  <= sio_s1_q;
    end
  end

  logic rise_c, fall_c;
  assign rise_c = sclk_s2_q & ~sclk_s3_q;
  assign fall_c = ~sclk_s2_q & sclk_s3_q;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [6:0]        sh_q, sh_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic              is_rd_q, is_rd_d;
  logic              nib_hi_q, nib_hi_d;
  logic              qpi_q, qpi_d;
  logic              rst_en_q, rst_en_d;
  logic [7:0]        last_cmd_q, last_cmd_d;
  logic [3:0]        sio_o_q, sio_o_d;
  logic              sio_oe_q, sio_oe_d;

  logic [7:0] mem_q [DEPTH];
  logic       we_c;
  logic [7:0] wdata_c;
  logic [7:0] rd_byte_c;
  logic [7:0] byte_nib_c, byte_bit_c, cmd_byte_c;
  logic       cmd_done_c;

  assign rd_byte_c  = mem_q[addr_q];
  // Byte assembly: QPI shifts a nibble, SPI shifts one bit on sio[0]
  assign byte_nib_c = {sh_q[3:0], sio_s2_q};
  assign byte_bit_c = {sh_q, sio_s2_q[0]};
  assign cmd_byte_c = qpi_q ? byte_nib_c : byte_bit_c;
  assign cmd_done_c = qpi_q ? (cnt_q == CNT_W'(1)) : (cnt_q == CNT_W'(7));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_CMD;
      cnt_q      <= '0;
      sh_q       <= 7'h00;
      addr_q     <= '0;
      is_rd_q    <= 1'b0;
      nib_hi_q   <= 1'b1;
      qpi_q      <= 1'b0;
      rst_en_q   <= 1'b0;
      last_cmd_q <= 8'h00;
      sio_o_q    <= 4'h0;
      sio_oe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      addr_q     <= addr_d;
      is_rd_q    <= is_rd_d;
      nib_hi_q   <= nib_hi_d;
      qpi_q      <= qpi_d;
      rst_en_q   <= rst_en_d;
      last_cmd_q <= last_cmd_d;
      sio_o_q    <= sio_o_d;
      sio_oe_q   <= sio_oe_d;
    end
  end

  // Memory contents survive reset
  always_ff @(posedge clk) begin
    if (we_c) mem_q[addr_q] <= wdata_c;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    addr_d     = addr_q;
    is_rd_d    = is_rd_q;
    nib_hi_d   = nib_hi_q;
    qpi_d      = qpi_q;
    rst_en_d   = rst_en_q;
    last_cmd_d = last_cmd_q;
    sio_o_d    = sio_o_q;
    sio_oe_d   = sio_oe_q;
    we_c       = 1'b0;
    wdata_c    = 8'h00;

    // Deselect dominates any same-cycle sclk edge
    if (ce_s2_q) begin
      state_d  = S_CMD;
      cnt_d    = '0;
      nib_hi_d = 1'b1;
      sio_oe_d = 1'b0;
    end else begin
      case (state_q)
        S_CMD: begin
          if (rise_c) begin
            sh_d  = cmd_byte_c[6:0];
            cnt_d = cnt_q + CNT_W'(1);
            if (cmd_done_c) begin
              cnt_d      = '0;
              last_cmd_d = cmd_byte_c;
              state_d    = S_IGNORE;
              rst_en_d   = 1'b0;
              case (cmd_byte_c)
                8'h66: rst_en_d = 1'b1;
                8'h99: if (rst_en_q) qpi_d = 1'b0;
                8'h35: if (!qpi_q) qpi_d = 1'b1;
                8'hF5: if (qpi_q) qpi_d = 1'b0;
                8'h38, 8'hEB: begin
                  if (qpi_q) begin
                    state_d = S_ADDR;
                    is_rd_d = (cmd_byte_c == 8'hEB);
                  end
                end
                default: ;
              endcase
            end
          end
        end
        S_ADDR: begin
          // High address bits shift out of the top and are dropped (aliasing)
          if (rise_c) begin
            addr_d = MEM_AW'({addr_q, sio_s2_q});
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(5)) begin
              cnt_d   = '0;
              state_d = is_rd_q ? S_WAIT : S_WR_DATA;
            end
          end
        end
        S_WAIT: begin
          if (rise_c) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WAIT_CYCLES - 1)) begin
              cnt_d    = '0;
              nib_hi_d = 1'b1;
              state_d  = S_RD_DATA;
            end
          end
        end
        S_WR_DATA: begin
          if (rise_c) begin
            sh_d = byte_nib_c[6:0];
            if (cnt_q == '0) begin
              cnt_d = CNT_W'(1);
            end else begin
              cnt_d   = '0;
              we_c    = 1'b1;
              wdata_c = byte_nib_c;
              addr_d  = addr_q + MEM_AW'(1);
            end
          end
        end
        S_RD_DATA: begin
          if (fall_c) begin
            sio_oe_d = 1'b1;
            sio_o_d  = nib_hi_q ? rd_byte_c[7:4] : rd_byte_c[3:0];
            nib_hi_d = ~nib_hi_q;
            if (!nib_hi_q) addr_d = addr_q + MEM_AW'(1);
          end
        end
        S_IGNORE: ;
        default: state_d = S_IGNORE;
      endcase
    end
  end

  assign sio_o    = sio_o_q;
  assign sio_oe   = sio_oe_q;
  assign qpi_mode = qpi_q;
  assign last_cmd = last_cmd_q;

endmodule

// File: tb/tb_psram_qpi_responder.sv
// Bench for psram_qpi_responder: a command table for mode handling plus
// scoreboarded quad write/read bursts covering wrap, abort and reset.
module tb_psram_qpi_responder;

  localparam int HALF = 50;
  localparam int WAITC = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       ce = 1'b1;
  logic [3:0] sio_i = 4'h0;
  logic [3:0] sio_o;
  logic       sio_oe;
  logic       qpi_mode;
  logic [7:0] last_cmd;

  always #5 clk = ~clk;

  psram_qpi_responder #(.MEM_AW(10), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .ce(ce), .sio_i(sio_i),
    .sio_o(sio_o), .sio_oe(sio_oe), .qpi_mode(qpi_mode), .last_cmd(last_cmd)
  );

  int         n_vec = 0;
  int         n_fail = 0;
  logic [3:0] exp_q[$];
  logic [7:0] model [1024];
  bit         oe_seen = 1'b0;

  typedef struct {
    logic [7:0] cmd;
    bit         qpi_frame;
    bit         exp_qpi;
    logic [7:0] exp_last;
  } vec_t;

  vec_t tbl [11];

  always @(posedge clk) if (sio_oe) oe_seen = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic clk_bit(input logic [3:0] v);
    sio_i = v;
    #HALF; sclk = 1'b1;
    #HALF; sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit q);
    if (q) begin
      clk_bit(b[7:4]);
      clk_bit(b[3:0]);
    end else begin
      for (int i = 7; i >= 0; i--) clk_bit({3'b000, b[i]});
    end
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) clk_bit(a[i*4 +: 4]);
  endtask

  task automatic cs_start();
    ce = 1'b0;
    #HALF;
  endtask

  task automatic cs_end();
    #HALF; ce = 1'b1; sio_i = 4'h0;
    #(4*HALF);
  endtask

  task automatic qpi_write(input logic [23:0] a, input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input int n);
    logic [7:0] d [3];
    logic [9:0] ma;
    d[0] = d0; d[1] = d1; d[2] = d2;
    ma = a[9:0];
    cs_start();
    send_byte(8'h38, 1'b1);
    send_addr(a);
    for (int i = 0; i < n; i++) begin
      send_byte(d[i], 1'b1);
      model[ma] = d[i];
      ma = ma + 10'd1;
    end
    cs_end();
  endtask

  // Opens a read burst, queues the expected nibbles and clocks the wait edges
  task automatic rd_open(input logic [23:0] a, input int n, input bit chk_wait);
    logic [9:0] ma;
    ma = a[9:0];
    cs_start();
    send_byte(8'hEB, 1'b1);
    send_addr(a);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(model[ma][7:4]);
      exp_q.push_back(model[ma][3:0]);
      ma = ma + 10'd1;
    end
    for (int w = 1; w <= WAITC; w++) begin
      sio_i = 4'h0;
      #HALF;
      if (chk_wait) check($sformatf("wait%0d_oe", w), 32'(sio_oe), 32'd0);
      sclk = 1'b1;
      #HALF; sclk = 1'b0;
    end
  endtask

  task automatic rd_nib();
    logic [3:0] e;
    #HALF;
    if (exp_q.size() == 0) begin
      n_vec++; n_fail++;
      $display("FAIL sb_empty: got nibble %0h, want none queued", sio_o);
    end else begin
      e = exp_q.pop_front();
      check("rd_nibble", 32'(sio_o), 32'(e));
      check("rd_oe", 32'(sio_oe), 32'd1);
    end
    sclk = 1'b1;
    #HALF; sclk = 1'b0;
  endtask

  task automatic qpi_read(input logic [23:0] a, input int n);
    rd_open(a, n, 1'b0);
    repeat (2*n) rd_nib();
    cs_end();
  endtask

  task automatic spi_frame(input logic [7:0] b);
    cs_start();
    send_byte(b, 1'b0);
    cs_end();
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{8'h66, 1'b0, 1'b0, 8'h66};
    tbl[1]  = '{8'h99, 1'b0, 1'b0, 8'h99};
    tbl[2]  = '{8'h35, 1'b0, 1'b1, 8'h35};
    tbl[3]  = '{8'h99, 1'b1, 1'b1, 8'h99};
    tbl[4]  = '{8'h35, 1'b1, 1'b1, 8'h35};
    tbl[5]  = '{8'h66, 1'b1, 1'b1, 8'h66};
    tbl[6]  = '{8'h99, 1'b1, 1'b0, 8'h99};
    tbl[7]  = '{8'hEB, 1'b0, 1'b0, 8'hEB};
    tbl[8]  = '{8'hF5, 1'b0, 1'b0, 8'hF5};
    tbl[9]  = '{8'h99, 1'b0, 1'b0, 8'h99};
    tbl[10] = '{8'h35, 1'b0, 1'b1, 8'h35};

    #100 rst_n = 1'b1;
    #20;
    check("rst_sio_o", 32'(sio_o), 32'd0);
    check("rst_oe", 32'(sio_oe), 32'd0);
    check("rst_qpi", 32'(qpi_mode), 32'd0);
    check("rst_last_cmd", 32'(last_cmd), 32'd0);

    // Mode and command-order table; trailing zero bytes confirm nothing is driven
    for (int i = 0; i < 11; i++) begin
      oe_seen = 1'b0;
      cs_start();
      send_byte(tbl[i].cmd, tbl[i].qpi_frame);
      repeat (4) send_byte(8'h00, tbl[i].qpi_frame);
      cs_end();
      check($sformatf("vec%0d_qpi", i), 32'(qpi_mode), 32'(tbl[i].exp_qpi));
      check($sformatf("vec%0d_last_cmd", i), 32'(last_cmd), 32'(tbl[i].exp_last));
      check($sformatf("vec%0d_no_drive", i), 32'(oe_seen), 32'd0);
    end

    // Write then read back with exact wait-edge accounting
    qpi_write(24'h000010, 8'hA5, 8'h3C, 8'h7E, 3);
    rd_open(24'h000010, 3, 1'b1);
    repeat (6) rd_nib();
    cs_end();
    check("rd_last_cmd", 32'(last_cmd), 32'hEB);
    check("rd_oe_after_ce", 32'(sio_oe), 32'd0);

    // Burst wrap at the top of memory and upper-address aliasing
    qpi_write(24'h0003FF, 8'h11, 8'h22, 8'h00, 2);
    qpi_read(24'h0403FF, 2);
    qpi_read(24'h000000, 1);

    // Partial byte discarded on deselect; sio_oe drops within 3 clk of ce
    qpi_write(24'h000020, 8'h5D, 8'h00, 8'h00, 1);
    cs_start();
    send_byte(8'h38, 1'b1);
    send_addr(24'h000020);
    clk_bit(4'hB);
    cs_end();
    rd_open(24'h000020, 1, 1'b0);
    rd_nib();
    rd_nib();
    check("oe_before_ce", 32'(sio_oe), 32'd1);
    @(negedge clk);
    ce = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("oe_3clk_after_ce", 32'(sio_oe), 32'd0);
    #(4*HALF);

    // Asynchronous reset in the middle of a read burst
    rd_open(24'h000010, 3, 1'b0);
    rd_nib();
    rd_nib();
    #7;
    rst_n = 1'b0;
    ce = 1'b1;
    #1;
    check("arst_oe", 32'(sio_oe), 32'd0);
    check("arst_qpi", 32'(qpi_mode), 32'd0);
    check("arst_last_cmd", 32'(last_cmd), 32'd0);
    exp_q.delete();
    #30 rst_n = 1'b1;
    #(4*HALF);
    spi_frame(8'h66);
    spi_frame(8'h99);
    spi_frame(8'h35);
    check("repower_qpi", 32'(qpi_mode), 32'd1);
    check("repower_last_cmd", 32'(last_cmd), 32'h35);
    qpi_read(24'h000010, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/psram_qpi_responder.md
Name: psram_qpi_responder

Overview:
- Synthesizable target-side model of the ESP-PSRAM64H SPI/QPI protocol, i.e. the memory-chip end of the PSRAM controller link.
- Oversamples the incoming sclk/ce/sio pins with the system clock and decodes the reset, enter-QPI, quad-write and quad-read commands.
- Serves a small internal byte memory.
- Uses: loopback self-test of the controller on FPGA, and a cycle-faithful device for simulation benches.

Parameters:
MEM_AW, 10, internal memory address width; depth 2^MEM_AW bytes; address bits above MEM_AW-1 ignored (aliasing)
WAIT_CYCLES, 6, sclk rising edges between the last address nibble and the first read-data nibble for 0xEB

Ports:
clk  input  1  system clock; must be at least 8x sclk, with sclk high and low phases each >= 4 clk periods
rst_n  input  1  asynchronous active-low reset
sclk  input  1  serial clock from the controller, asynchronous to clk
ce  input  1  chip enable, active-low
sio_i  input  4  pad inputs; bit0=SI/mosi, bit1=SO/miso, bit2=sio2, bit3=sio3
sio_o  output  4  pad output values
sio_oe  output  1  output enable for all four pads (1 = drive)
qpi_mode  output  1  1 when in QPI mode
last_cmd  output  8  last fully received command byte

Behaviour:
- Input conditioning: sclk, ce and sio_i each pass through a 2-FF synchronizer. Edges are detected on the synchronized sclk (one registered copy).
- Reset values: sio_o=0, sio_oe=0, qpi_mode=0, last_cmd=0, state=CMD, reset-enable flag=0. Memory contents are not reset.
- Synchronized ce high forces state CMD and clears bit/nibble counters and sio_oe from any state, within 3 clk of the pad change. The reset-enable flag is kept.
- Rising-edge sampling:
  - SPI mode: sio_i[0], MSB first, 8 edges per byte.
  - QPI mode: sio_i[3:0], high nibble first, 2 edges per byte.
- Falling-edge driving: read nibbles are driven on sclk falling edges only.
- States:
  - CMD: collect 1 byte, then update last_cmd and dispatch (below).
  - ADDR: collect 24 bits (6 nibbles, QPI only). Next state is WR_DATA for 0x38, or WAIT for 0xEB.
  - WAIT: count WAIT_CYCLES rising edges, then go to RD_DATA.
  - WR_DATA: assemble bytes; on the 2nd nibble of each byte, write mem[addr] and increment addr.
  - RD_DATA: on each falling edge drive the next nibble of mem[addr] (high nibble first) and assert sio_oe; increment addr after the low nibble is driven.
  - IGNORE: discard all edges until ce rises.
- Command dispatch:
  - 0x66: set the reset-enable flag; go to IGNORE.
  - 0x99:
    - if the flag is set: qpi_mode=0.
    - always: clear the flag; go to IGNORE.
  - 0x35, SPI mode only: qpi_mode=1; go to IGNORE.
  - 0xF5, QPI mode only: qpi_mode=0; go to IGNORE.
  - 0x38 or 0xEB, QPI mode only: go to ADDR.
  - Any other byte, or a command not valid in the current mode: go to IGNORE. The flag is cleared by any command other than 0x66.
- RD_DATA first-nibble timing: the first nibble is driven on the first falling edge after the WAIT_CYCLES-th wait rising edge. sio_oe stays 1 until ce rises.
- Address arithmetic: addr = a[MEM_AW-1:0]; increments modulo 2^MEM_AW, so a burst wraps from the top of memory to 0.
- Boundary cases:
  - ce rising mid-byte in WR_DATA: the partial byte is discarded and no write occurs.
  - ce rising in ADDR or WAIT: no memory access.
  - rst_n asserted mid-burst: immediate return to reset values; the in-flight byte is not written.
- Simultaneous sclk rising and ce rising, as seen after synchronization: ce wins and the edge is discarded.
- sio_oe is never asserted outside RD_DATA. A SPI-mode command never drives sio_oe.

Test Plan:
1. Power-up sequence (SPI): send 0x66, 0x99, 0x35, each framed by ce -> qpi_mode=1, last_cmd=0x35, sio_oe=0 throughout.
2. QPI write then read: write 0x38, addr 0x000010, data 0xA5 0x3C 0x7E; then read 0xEB at 0x000010 for 3 bytes.
   - Required: nibbles A,5,3,C,7,E appear after exactly 6 wait edges; sio_oe rises on the first falling edge after wait.
3. Wrap and alias: with MEM_AW=10, write 0x11, 0x22 at 0x0003FF, then read at 0x0403FF.
   - Required: 0x11 then 0x22, and mem[0x000]=0x22.
4. Abort mid-byte: 0x38, addr 0x20, nibbles 0xB then ce high; then read 0x20.
   - Required: the old value is unchanged; sio_oe=0 within 3 clk of ce rising.
5. Illegal order and mode:
   - 0x99 without a preceding 0x66 -> qpi_mode unchanged.
   - 0xEB sent in SPI mode -> IGNORE, no drive.
   - 0x66, 0x99 sent in QPI mode -> qpi_mode=0.
6. rst_n pulsed low during an RD_DATA burst -> sio_oe=0 and qpi_mode=0 immediately (asynchronously); a fresh power-up sequence works afterwards.
